// File: rtl/regfile_lock.sv
// Two-read/one-write register file with per-register pending bits, a lock
// handshake, optional write-to-read bypass and a sequenced bulk-clear engine.
module regfile_lock #(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 8,
    parameter int AW     = 3,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AW-1:0]    writenum,
    input  logic             write,
    input  logic [AW-1:0]    readnum_a,
    input  logic [AW-1:0]    readnum_b,
    output logic [WIDTH-1:0] data_out_a,
    output logic [WIDTH-1:0] data_out_b,
    output logic             busy_a,
    output logic             busy_b,
    input  logic             lock,
    input  logic [AW-1:0]    locknum,
    output logic             lock_ok,
    input  logic             clear,
    output logic             clearing
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_reg, state_next;
    logic [AW-1:0]     ptr_reg, ptr_next;
    logic [WIDTH-1:0]  regs_reg [NREGS];
    logic [NREGS-1:0]  pending_reg;

    logic [NREGS-1:0]  write_hit, lock_sel, lock_hit, clear_hit, rd_hit_a, rd_hit_b;
    logic              idle;

    assign idle     = (state_reg == IDLE);
    assign clearing = (state_reg == CLEAR);

    // One-hot decodes; an out-of-range index simply matches no register.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_decode
            assign write_hit[gi] = write && idle && (writenum == AW'(gi));
            assign lock_sel[gi]  = (locknum == AW'(gi));
            assign lock_hit[gi]  = lock_ok && lock_sel[gi];
            assign clear_hit[gi] = clearing && (ptr_reg == AW'(gi));
            assign rd_hit_a[gi]  = (readnum_a == AW'(gi));
            assign rd_hit_b[gi]  = (readnum_b == AW'(gi));
        end
    endgenerate

    assign lock_ok = lock && idle && |(lock_sel & ~pending_reg);

    always_comb begin
        data_out_a = '1;
        data_out_b = '1;
        busy_a     = 1'b0;
        busy_b     = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (rd_hit_a[i]) begin
                data_out_a = regs_reg[i];
                busy_a     = pending_reg[i];
            end
            if (rd_hit_b[i]) begin
                data_out_b = regs_reg[i];
                busy_b     = pending_reg[i];
            end
        end
        // write_hit already excludes CLEAR, so forwarding is off while clearing
        if (BYPASS != 0 && |(write_hit & rd_hit_a)) begin
            data_out_a = data_in;
            busy_a     = 1'b0;
        end
        if (BYPASS != 0 && |(write_hit & rd_hit_b)) begin
            data_out_b = data_in;
            busy_b     = 1'b0;
        end
    end

    // A lock granted alongside a write to the same entry wins the pending bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i]    <= '0;
                pending_reg[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (clear_hit[i]) begin
                    regs_reg[i]    <= '0;
                    pending_reg[i] <= 1'b0;
                end else begin
                    if (write_hit[i])
                        regs_reg[i] <= data_in;
                    if (lock_hit[i])
                        pending_reg[i] <= 1'b1;
                    else if (write_hit[i])
                        pending_reg[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (clear) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            CLEAR: begin
                ptr_next = ptr_reg + 1'b1;
                if (ptr_reg == AW'(NREGS - 1))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
